// File: rtl/muldiv_sched.sv
// Sequencer and sole owner of the shared iterative multiply/divide unit and the HI/LO write port.
// Optional macro DIV0_FAST_EN: divide-by-zero bypasses the iterations and completes in one busy cycle.
module muldiv_sched #(
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned DIV_CYCLES = 34,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [1:0] op_code,
    input  logic       op_b_zero,
    input  logic       hilo_rd,
    output logic       stall,
    output logic       busy,
    output logic       unit_start,
    output logic [5:0] unit_ctrl,
    output logic       hilo_we,
    output logic       div0_fix
);

    localparam int unsigned CTRL_W    = 6;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 6'b000000;
    localparam logic [CTRL_W-1:0] CTRL_DONE = 6'b111111;
    localparam logic [3:0]        FUNCT_HI  = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CTRL_W-1:0] unit_ctrl_nxt;
    logic              unit_start_nxt;
    logic              hilo_we_nxt;
    logic              div0_fix_nxt;
    logic              busy_nxt;
    logic              fast_div0;

`ifdef DIV0_FAST_EN
    assign fast_div0 = (state == IDLE) && op_valid && op_code[1] && op_b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = op_b_zero;
    assign fast_div0     = 1'b0;
`endif

    // Registered state, counter and unit-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            unit_ctrl  <= CTRL_IDLE;
            unit_start <= 1'b0;
            hilo_we    <= 1'b0;
            div0_fix   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            unit_ctrl  <= unit_ctrl_nxt;
            unit_start <= unit_start_nxt;
            hilo_we    <= hilo_we_nxt;
            div0_fix   <= div0_fix_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and iteration counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (fast_div0) begin
                    state_nxt = DONE;
                end else if (op_valid) begin
                    state_nxt = RUN;
                    cnt_nxt   = op_code[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        unit_ctrl_nxt  = CTRL_IDLE;
        unit_start_nxt = 1'b0;
        hilo_we_nxt    = 1'b0;
        div0_fix_nxt   = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        case (state_nxt)
            RUN: begin
                unit_start_nxt = (state == IDLE);
                unit_ctrl_nxt  = (state == IDLE) ? {FUNCT_HI, op_code} : unit_ctrl;
            end
            DONE: begin
                unit_ctrl_nxt = CTRL_DONE;
                hilo_we_nxt   = 1'b1;
                div0_fix_nxt  = fast_div0;
            end
            default: unit_ctrl_nxt = CTRL_IDLE;
        endcase
    end

    // DONE still stalls: HI/LO is only written at the end of that cycle
    assign stall = busy & (op_valid | hilo_rd);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched with hand-derived cycle expectations.
// Define DIV0_FAST_EN for both bench and RTL to exercise the fast divide-by-zero path.
`timescale 1ns/1ps
module tb_muldiv_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic [1:0] op_code;
    logic       op_b_zero;
    logic       hilo_rd;
    logic       stall;
    logic       busy;
    logic       unit_start;
    logic [5:0] unit_ctrl;
    logic       hilo_we;
    logic       div0_fix;

    int checks;
    int errors;

    always #5 clk = ~clk;

    muldiv_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_b_zero  (op_b_zero),
        .hilo_rd    (hilo_rd),
        .stall      (stall),
        .busy       (busy),
        .unit_start (unit_start),
        .unit_ctrl  (unit_ctrl),
        .hilo_we    (hilo_we),
        .div0_fix   (div0_fix)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step into the next cycle, slightly after the rising edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_start"}, 32'(unit_start), 32'd0);
        check({tag, "_ctrl"},  32'(unit_ctrl),  32'd0);
        check({tag, "_we"},    32'(hilo_we),    32'd0);
        check({tag, "_fix"},   32'(div0_fix),   32'd0);
    endtask

    initial begin
        logic seen_we;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'b00;
        op_b_zero = 1'b0;
        hilo_rd   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        hilo_rd = 1'b1;
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        hilo_rd = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // MULTU 7x9
        cyc;
        op_valid = 1'b1;
        op_code  = 2'b01;
        #2;
        check("multu_issue_stall", 32'(stall), 32'd0);
        for (int k = 1; k <= 34; k++) begin
            cyc;
            if (k == 1) op_valid = 1'b0;
            #2;
            check($sformatf("multu_start_%0d", k), 32'(unit_start), 32'(k == 1));
            check($sformatf("multu_we_%0d", k),    32'(hilo_we),    32'(k == 33));
            check($sformatf("multu_busy_%0d", k),  32'(busy),       32'(k <= 33));
            check($sformatf("multu_ctrl_%0d", k),  32'(unit_ctrl),
                  (k <= 32) ? 32'h19 : (k == 33) ? 32'h3F : 32'h00);
        end

        // DIVU 100/7 followed by MFLO held in EX
        cyc;
        op_valid = 1'b1;
        op_code  = 2'b11;
        #2;
        check("divu_issue_stall", 32'(stall), 32'd0);
        for (int k = 1; k <= 36; k++) begin
            cyc;
            if (k == 1) begin
                op_valid = 1'b0;
                hilo_rd  = 1'b1;
            end
            #2;
            check($sformatf("mflo_stall_%0d", k), 32'(stall),   32'(k <= 35));
            check($sformatf("divu_we_%0d", k),    32'(hilo_we), 32'(k == 35));
            if (k == 1) check("divu_ctrl", 32'(unit_ctrl), 32'h1B);
        end
        hilo_rd = 1'b0;

        // Back-to-back MULT then DIV presented while busy
        cyc;
        op_valid = 1'b1;
        op_code  = 2'b00;
        #2;
        for (int k = 1; k <= 70; k++) begin
            cyc;
            if (k == 1)  op_code  = 2'b10;
            if (k == 35) op_valid = 1'b0;
            #2;
            if (k <= 34) check($sformatf("b2b_stall_%0d", k), 32'(stall), 32'(k <= 33));
            check($sformatf("b2b_we_%0d", k),    32'(hilo_we),    32'(k == 33 || k == 69));
            check($sformatf("b2b_start_%0d", k), 32'(unit_start), 32'(k == 1 || k == 35));
            if (k == 1)  check("b2b_ctrl_mult", 32'(unit_ctrl), 32'h18);
            if (k == 35) check("b2b_ctrl_div",  32'(unit_ctrl), 32'h1A);
        end

        // DIV with zero divisor
        cyc;
        op_valid  = 1'b1;
        op_code   = 2'b10;
        op_b_zero = 1'b1;
        #2;
`ifdef DIV0_FAST_EN
        for (int k = 1; k <= 2; k++) begin
            cyc;
            if (k == 1) begin
                op_valid  = 1'b0;
                op_b_zero = 1'b0;
            end
            #2;
            check($sformatf("div0f_busy_%0d", k),  32'(busy),       32'(k == 1));
            check($sformatf("div0f_we_%0d", k),    32'(hilo_we),    32'(k == 1));
            check($sformatf("div0f_fix_%0d", k),   32'(div0_fix),   32'(k == 1));
            check($sformatf("div0f_start_%0d", k), 32'(unit_start), 32'd0);
            check($sformatf("div0f_ctrl_%0d", k),  32'(unit_ctrl),  (k == 1) ? 32'h3F : 32'h00);
        end
`else
        for (int k = 1; k <= 36; k++) begin
            cyc;
            if (k == 1) begin
                op_valid  = 1'b0;
                op_b_zero = 1'b0;
            end
            #2;
            check($sformatf("div0_we_%0d", k),    32'(hilo_we),    32'(k == 35));
            check($sformatf("div0_fix_%0d", k),   32'(div0_fix),   32'd0);
            check($sformatf("div0_start_%0d", k), 32'(unit_start), 32'(k == 1));
            check($sformatf("div0_busy_%0d", k),  32'(busy),       32'(k <= 35));
        end
`endif

        // Asynchronous reset in cycle 10 of a MULT
        cyc;
        op_valid = 1'b1;
        op_code  = 2'b00;
        #2;
        for (int k = 1; k <= 10; k++) begin
            cyc;
            if (k == 1) op_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_rst");
        repeat (2) cyc;
        rst_n   = 1'b1;
        seen_we = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc;
            #2;
            if (hilo_we || busy) seen_we = 1'b1;
        end
        check("post_rst_quiet", 32'(seen_we), 32'd0);

        // Normal acceptance after reset
        cyc;
        op_valid = 1'b1;
        op_code  = 2'b00;
        #2;
        for (int k = 1; k <= 34; k++) begin
            cyc;
            if (k == 1) op_valid = 1'b0;
            #2;
            if (k == 1) check("post_rst_ctrl", 32'(unit_ctrl), 32'h18);
            check($sformatf("post_rst_start_%0d", k), 32'(unit_start), 32'(k == 1));
            check($sformatf("post_rst_we_%0d", k),    32'(hilo_we),    32'(k == 33));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
